// File: rtl/bcd999_timer_ctrl.sv
// Three-digit BCD up-counter with a prescaled tick, a latched terminal count and
// an IDLE/RUN/HOLD/DONE control FSM. The counter either stops or auto-reloads on a match.

module bcd999_digit (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] q
);
    always_comb begin
        q = d;
        if (cin) q = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    end
endmodule

module bcd999_timer_ctrl #(
    parameter int unsigned PRESCALE   = 1,
    parameter bit          AUTORELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic [3:0] tgt_hun,
    input  logic [3:0] tgt_ten,
    input  logic [3:0] tgt_unit,
    output logic [3:0] hun,
    output logic [3:0] ten,
    output logic [3:0] unit,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int          NUM_DIG = 3;
    localparam logic [15:0] PS_MAX  = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t                  state, state_nxt;
    logic [NUM_DIG-1:0][3:0] dig, dig_nxt, dig_inc, tgt, tgt_nxt, tgt_in;
    logic [NUM_DIG-1:0]      carry, dig_ok;
    logic [15:0]             psc, psc_nxt;
    logic                    done_nxt, err_nxt, tgt_ok, tick, match, go_req;

    assign tgt_in   = {tgt_hun, tgt_ten, tgt_unit};
    assign carry[0] = 1'b1;

    // Index 0 is the unit digit; carry ripples upward only through 9s.
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        bcd999_digit u_dig (
            .d  (dig[i]),
            .cin(carry[i]),
            .q  (dig_inc[i])
        );
        assign dig_ok[i] = (tgt_in[i] <= 4'd9);
        if (i < NUM_DIG - 1) begin : g_carry
            assign carry[i+1] = carry[i] && (dig[i] == 4'd9);
        end
    end

    assign tgt_ok = &dig_ok;
    assign tick   = (psc == PS_MAX);
    assign match  = (dig == tgt);
    assign go_req = start && !stop;

    always_comb begin
        state_nxt = state;
        dig_nxt   = dig;
        tgt_nxt   = tgt;
        psc_nxt   = psc;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            dig_nxt   = '0;
            psc_nxt   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go_req) begin
                        if (tgt_ok) begin
                            tgt_nxt   = tgt_in;
                            dig_nxt   = '0;
                            psc_nxt   = '0;
                            state_nxt = RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A tick landing on the stop cycle is dropped, prescaler frozen.
                    if (stop) begin
                        state_nxt = HOLD;
                    end else if (tick) begin
                        psc_nxt = '0;
                        if (match) begin
                            done_nxt = 1'b1;
                            if (AUTORELOAD) dig_nxt = '0;
                            else            state_nxt = DONE;
                        end else begin
                            dig_nxt = dig_inc;
                        end
                    end else begin
                        psc_nxt = psc + 16'd1;
                    end
                end
                HOLD: begin
                    if (go_req) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dig   <= '0;
            tgt   <= '0;
            psc   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            dig   <= dig_nxt;
            tgt   <= tgt_nxt;
            psc   <= psc_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    assign hun  = dig[2];
    assign ten  = dig[1];
    assign unit = dig[0];
    assign busy = (state == RUN) || (state == HOLD);
endmodule

// File: tb/tb_bcd999_timer_ctrl.sv
// Directed bench for bcd999_timer_ctrl: three instances (P=1 stop, P=3 stop, P=1 reload)
// share one stimulus; each scenario checks the instance it targets.

module tb_bcd999_timer_ctrl;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0;
    logic [3:0] tgt_hun = 4'd0, tgt_ten = 4'd0, tgt_unit = 4'd0;
    logic [3:0] hun0, ten0, unit0, hun3, ten3, unit3, huna, tena, unita;
    logic busy0, done0, err0, busy3, done3, err3, busya, donea, erra;
    logic [11:0] d0, d3, da;
    int n_chk = 0, n_fail = 0;

    assign d0 = {hun0, ten0, unit0};
    assign d3 = {hun3, ten3, unit3};
    assign da = {huna, tena, unita};

    always #5 clk = ~clk;

    bcd999_timer_ctrl #(.PRESCALE(1), .AUTORELOAD(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .tgt_hun(tgt_hun), .tgt_ten(tgt_ten), .tgt_unit(tgt_unit),
        .hun(hun0), .ten(ten0), .unit(unit0), .busy(busy0), .done(done0), .err(err0));
    bcd999_timer_ctrl #(.PRESCALE(3), .AUTORELOAD(1'b0)) u3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .tgt_hun(tgt_hun), .tgt_ten(tgt_ten), .tgt_unit(tgt_unit),
        .hun(hun3), .ten(ten3), .unit(unit3), .busy(busy3), .done(done3), .err(err3));
    bcd999_timer_ctrl #(.PRESCALE(1), .AUTORELOAD(1'b1)) ua (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
        .tgt_hun(tgt_hun), .tgt_ten(tgt_ten), .tgt_unit(tgt_unit),
        .hun(huna), .ten(tena), .unit(unita), .busy(busya), .done(donea), .err(erra));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic go(input logic [11:0] t);
        {tgt_hun, tgt_ten, tgt_unit} = t;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        if ({d0, busy0, done0, err0} !== 15'd0) begin
            $display("FAIL reset_async act=%h exp=0", {d0, busy0, done0, err0}); n_fail++;
        end
        n_chk++;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        if ({d3, busy3, done3, err3, da, busya, donea, erra} !== 30'd0) begin
            $display("FAIL reset_state act=%h exp=0", {d3, busy3, done3, err3, da, busya, donea, erra}); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_count5();
        do_clr();
        go(12'h005);
        if (busy0 !== 1'b1 || d0 !== 12'h000) begin
            $display("FAIL cnt5_start busy=%b d=%h exp busy=1 d=000", busy0, d0); n_fail++;
        end
        n_chk++;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (d0 !== 12'(i) || done0 !== 1'b0) begin
                $display("FAIL cnt5_step%0d d=%h done=%b exp d=%h done=0", i, d0, done0, 12'(i)); n_fail++;
            end
            n_chk++;
        end
        cyc();
        if (done0 !== 1'b1 || busy0 !== 1'b0 || d0 !== 12'h005) begin
            $display("FAIL cnt5_done done=%b busy=%b d=%h exp 1 0 005", done0, busy0, d0); n_fail++;
        end
        n_chk++;
        cyc();
        if (done0 !== 1'b0 || d0 !== 12'h005) begin
            $display("FAIL cnt5_hold done=%b d=%h exp 0 005", done0, d0); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_zero();
        do_clr();
        go(12'h000);
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
            $display("FAIL zero_start done=%b busy=%b exp 0 1", done0, busy0); n_fail++;
        end
        n_chk++;
        cyc();
        if (done0 !== 1'b1 || busy0 !== 1'b0 || d0 !== 12'h000) begin
            $display("FAIL zero_match done=%b busy=%b d=%h exp 1 0 000", done0, busy0, d0); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_999();
        logic [11:0] e;
        do_clr();
        go(12'h999);
        for (int n = 1; n <= 999; n++) begin
            cyc();
            e = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            if (d0 !== e || done0 !== 1'b0) begin
                $display("FAIL c999_n%0d d=%h done=%b exp d=%h done=0", n, d0, done0, e); n_fail++;
            end
            n_chk++;
        end
        cyc();
        if (done0 !== 1'b1 || d0 !== 12'h999 || busy0 !== 1'b0) begin
            $display("FAIL c999_done done=%b d=%h busy=%b exp 1 999 0", done0, d0, busy0); n_fail++;
        end
        n_chk++;
        cyc();
        if (done0 !== 1'b0 || d0 !== 12'h999) begin
            $display("FAIL c999_nowrap done=%b d=%h exp 0 999", done0, d0); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_hold();
        do_clr();
        go(12'h002);
        cyc(); cyc(); cyc();
        if (d3 !== 12'h001) begin
            $display("FAIL hold_pre d=%h exp 001", d3); n_fail++;
        end
        n_chk++;
        stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (d3 !== 12'h001 || busy3 !== 1'b1) begin
                $display("FAIL hold_c%0d d=%h busy=%b exp 001 1", i, d3, busy3); n_fail++;
            end
            n_chk++;
        end
        stop = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        if (d3 !== 12'h001) begin
            $display("FAIL hold_resume d=%h exp 001", d3); n_fail++;
        end
        n_chk++;
        cyc();
        if (d3 !== 12'h002 || done3 !== 1'b0) begin
            $display("FAIL hold_two d=%h done=%b exp 002 0", d3, done3); n_fail++;
        end
        n_chk++;
        cyc(); cyc(); cyc();
        if (done3 !== 1'b1 || busy3 !== 1'b0 || d3 !== 12'h002) begin
            $display("FAIL hold_done done=%b busy=%b d=%h exp 1 0 002", done3, busy3, d3); n_fail++;
        end
        n_chk++;
        // restart from DONE, then stop exactly on the tick cycle
        go(12'h001);
        cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        if (d3 !== 12'h000 || busy3 !== 1'b1) begin
            $display("FAIL tick_drop d=%h busy=%b exp 000 1", d3, busy3); n_fail++;
        end
        n_chk++;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        if (d3 !== 12'h001) begin
            $display("FAIL tick_resume d=%h exp 001", d3); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_err();
        do_clr();
        tgt_hun = 4'd0; tgt_ten = 4'hA; tgt_unit = 4'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (err0 !== 1'b1 || busy0 !== 1'b0 || d0 !== 12'h000) begin
            $display("FAIL err_pulse err=%b busy=%b d=%h exp 1 0 000", err0, busy0, d0); n_fail++;
        end
        n_chk++;
        cyc();
        if (err0 !== 1'b0 || busy0 !== 1'b0) begin
            $display("FAIL err_clear err=%b busy=%b exp 0 0", err0, busy0); n_fail++;
        end
        n_chk++;
    endtask

    task automatic test_autoreload();
        logic [3:0] eu [7];
        logic       ed [7];
        eu = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_clr();
        go(12'h002);
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (da !== {8'h00, eu[i]} || donea !== ed[i] || busya !== 1'b1) begin
                $display("FAIL reload_c%0d d=%h done=%b busy=%b exp d=%h done=%b busy=1",
                         i, da, donea, busya, {8'h00, eu[i]}, ed[i]); n_fail++;
            end
            n_chk++;
        end
    endtask

    task automatic test_rst_mid();
        do_clr();
        go(12'h999);
        repeat (347) cyc();
        if (d0 !== 12'h347) begin
            $display("FAIL rst_mid_pre d=%h exp 347", d0); n_fail++;
        end
        n_chk++;
        #2 rst = 1'b1;
        #1;
        if (d0 !== 12'h000 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            $display("FAIL rst_mid_async d=%h busy=%b done=%b exp 000 0 0", d0, busy0, done0); n_fail++;
        end
        n_chk++;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (d0 !== 12'h000 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                $display("FAIL rst_mid_after%0d d=%h busy=%b done=%b exp 000 0 0", i, d0, busy0, done0); n_fail++;
            end
            n_chk++;
        end
    endtask

    task automatic test_clr_combo();
        do_clr();
        go(12'h999);
        repeat (20) cyc();
        clr = 1'b1; stop = 1'b1; start = 1'b1;
        cyc();
        clr = 1'b0; stop = 1'b0; start = 1'b0;
        if (d0 !== 12'h000 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            $display("FAIL clr_combo d=%h busy=%b done=%b exp 000 0 0", d0, busy0, done0); n_fail++;
        end
        n_chk++;
        cyc();
        if (d0 !== 12'h000 || busy0 !== 1'b0) begin
            $display("FAIL clr_combo_idle d=%h busy=%b exp 000 0", d0, busy0); n_fail++;
        end
        n_chk++;
    endtask

    initial begin
        test_reset();
        test_count5();
        test_zero();
        test_999();
        test_hold();
        test_err();
        test_autoreload();
        test_rst_mid();
        test_clr_combo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd999_timer_ctrl.md
BCD999_TIMER_CTRL -- requirements
Module: bcd999_timer_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, clock cycles per count tick (legal range 1..65535).
REQ-002 SHALL have parameter AUTORELOAD, default 0; 1 = restart from 000 on match, 0 = stop on match.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  start/resume request, sampled each cycle.
REQ-006 SHALL have port stop  input  1  pause request, sampled each cycle.
REQ-007 SHALL have port clr  input  1  synchronous clear to idle.
REQ-008 SHALL have ports tgt_hun, tgt_ten, tgt_unit  input  4 each  BCD terminal count.
REQ-009 SHALL have ports hun, ten, unit  output  4 each  current BCD count, registered.
REQ-010 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-011 SHALL have port done  output  1  one-cycle pulse on terminal match.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected (non-BCD) target.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HOLD, DONE.
REQ-014 Input priority SHALL be clr > stop > start when asserted together.
REQ-015 clr in any state SHALL force IDLE, digits 000, prescaler 0, done/err 0 on the next edge.
REQ-016 IDLE + start + all target digits <= 9 SHALL latch target, clear digits and prescaler, go RUN.
REQ-017 IDLE + start + any target digit > 9 SHALL stay IDLE and pulse err one cycle; digits unchanged.
REQ-018 In RUN the prescaler SHALL count 0..PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, then it returns to 0.
REQ-019 On a tick with digits != latched target, digits SHALL increment in BCD: unit 9->0 carries to ten; ten 9->0 with unit 9 carries to hun.
REQ-020 On a tick with digits == latched target, done SHALL be 1 for exactly the following cycle.
REQ-021 On match with AUTORELOAD=0, state SHALL go DONE and digits SHALL hold the target value.
REQ-022 On match with AUTORELOAD=1, digits SHALL load 000 and state SHALL stay RUN.
REQ-023 Target 000 SHALL match on the first tick after start.
REQ-024 Since target <= 999, digits SHALL never wrap past 999; digits SHALL never hold a non-BCD value.
REQ-025 RUN + stop SHALL go HOLD; digits and prescaler frozen; a tick coinciding with stop SHALL be discarded.
REQ-026 HOLD + start (no stop) SHALL return to RUN, resuming prescaler and digits without reload.
REQ-027 start in RUN, stop in IDLE/HOLD/DONE SHALL have no effect; tgt_* SHALL be ignored except on the IDLE/DONE start edge.
REQ-028 DONE + valid start SHALL behave as REQ-016 (new target latch, restart from 000); invalid start as REQ-017 but staying DONE.
REQ-029 Latency: start sampled at edge k -> RUN at k; with PRESCALE=P, unit=1 after edge k+P.
REQ-030 busy SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-031 rst high SHALL immediately force IDLE, hun/ten/unit=0, prescaler=0, latched target=0, busy=0, done=0, err=0, regardless of clk.
REQ-032 rst deasserted mid-RUN SHALL resume from IDLE; no done pulse SHALL be emitted for the aborted run.

Verification
REQ-033 P=1, target 005, start pulse -> unit 1,2,3,4,5 on successive edges, done high one cycle after 005, state DONE, digits hold 005.
REQ-034 P=1, target 999 -> 009->010 and 099->100 carries correct; done after 999 reached; 1000 ticks total; no wrap.
REQ-035 P=3, target 002, stop asserted after count 001 for 10 cycles then start -> count frozen at 001 during HOLD, busy=1, resumes and done after 002.
REQ-036 Target tgt_ten=4'hA with start in IDLE -> err pulse one cycle, busy=0, digits stay 000.
REQ-037 AUTORELOAD=1, target 002 -> sequence 000,001,002,000,001,002..., done pulse each match, busy stays 1.
REQ-038 rst asserted mid-count at 347, and separately clr+stop+start in same cycle -> digits 000, IDLE, done=0 in both cases.
